// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
//   ctrl_state_e : RUN / MC_WAIT / FLUSH sequencing states
//   REG_IDX_W    : architectural register index width for 32 registers
//   ctrl_out_t   : bundle of the per-cycle pipeline control strobes
package pipe_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      FLUSH   = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic issue;
      logic stall_if;
      logic bubble_ex;
      logic kill_if;
   } ctrl_out_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy-bit scoreboard.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset (clears all bits)
//   set_en / set_idx      : mark a destination busy (ignored for x0)
//   clr_en / clr_idx      : writeback clear
//   abort_en / abort_idx  : clear for an abandoned multi-cycle op
//   rd_idx_a/b, busy_a/b  : two combinational lookups of the registered bits
//   busy                  : full busy vector
// A set and a clear of the same register in one cycle leaves the bit set.
module reg_scoreboard #(
   parameter int NREGS = 32,
   parameter int IW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_en,
   input  logic [IW-1:0]    set_idx,
   input  logic             clr_en,
   input  logic [IW-1:0]    clr_idx,
   input  logic             abort_en,
   input  logic [IW-1:0]    abort_idx,
   input  logic [IW-1:0]    rd_idx_a,
   input  logic [IW-1:0]    rd_idx_b,
   output logic             busy_a,
   output logic             busy_b,
   output logic [NREGS-1:0] busy
);

   logic [NREGS-1:0] busy_nxt;

   // Clears are applied first so that a same-cycle set overrides them.
   always_comb begin
      busy_nxt = busy;
      if (clr_en)
         busy_nxt[clr_idx] = 1'b0;
      if (abort_en)
         busy_nxt[abort_idx] = 1'b0;
      if (set_en && (set_idx != '0))
         busy_nxt[set_idx] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign busy_a = (rd_idx_a != '0) & busy[rd_idx_a];
   assign busy_b = (rd_idx_b != '0) & busy[rd_idx_b];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the IF/ID/EX front end.
// Decides each cycle whether the ID instruction issues, stalls or is flushed,
// kills fetched instructions after a taken jump and blocks issue while a
// multi-cycle op is in flight (with a sticky watchdog error).
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   id_valid, id_rs1/2, id_use_rs1/2  : ID instruction and its sources
//   id_rd, id_we, id_multi, jmp       : destination, write enable, multi-cycle, taken jump
//   wb_valid, wb_rd                   : register file writeback
//   mc_done                           : multi-cycle unit completion pulse
//   issue, stall_if, bubble_ex, kill_if : pipeline control strobes (0 while reset)
//   mc_err                            : sticky watchdog error
//   sb_busy                           : scoreboard busy bits (debug)
// Build option: PIPE_HAZARD_CTRL_WB_BYPASS_EN treats a source being written
// back in the same cycle as not busy (write-through register file).
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES  = 1,
   parameter int MC_MAX_CYCLES = 34,
   parameter int NREGS         = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [$clog2(NREGS)-1:0] id_rs1,
   input  logic [$clog2(NREGS)-1:0] id_rs2,
   input  logic                     id_use_rs1,
   input  logic                     id_use_rs2,
   input  logic [$clog2(NREGS)-1:0] id_rd,
   input  logic                     id_we,
   input  logic                     id_multi,
   input  logic                     jmp,
   input  logic                     wb_valid,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   input  logic                     mc_done,
   output logic                     issue,
   output logic                     stall_if,
   output logic                     bubble_ex,
   output logic                     kill_if,
   output logic                     mc_err,
   output logic [NREGS-1:0]         sb_busy
);

   import pipe_ctrl_pkg::*;

   localparam int IW  = $clog2(NREGS);
   localparam int MCW = $clog2(MC_MAX_CYCLES + 1);

   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_MC    = MC_WAIT;
   localparam logic [1:0] ST_FLUSH = FLUSH;

   logic [1:0]     state;
   logic [2:0]     flush_cnt;
   logic [MCW-1:0] mc_cnt;
   logic [IW-1:0]  mc_rd;
   ctrl_out_t      ctl;

   logic busy1, busy2, byp1, byp2, hazard, wd_fire;

`ifdef PIPE_HAZARD_CTRL_WB_BYPASS_EN
   assign byp1 = wb_valid & (wb_rd == id_rs1);
   assign byp2 = wb_valid & (wb_rd == id_rs2);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign hazard = id_valid & ((id_use_rs1 & busy1 & ~byp1) |
                               (id_use_rs2 & busy2 & ~byp2));

   // Watchdog expiry: the last permitted MC_WAIT cycle passed without mc_done.
   assign wd_fire = (state == ST_MC) & ~mc_done &
                    (mc_cnt == MCW'(MC_MAX_CYCLES - 1));

   always_comb begin
      ctl = '0;
      if (!reset) begin
         case (state)
            ST_RUN: begin
               ctl.issue     = id_valid & ~hazard;
               ctl.stall_if  = id_valid & hazard;
               ctl.bubble_ex = ~(id_valid & ~hazard);
            end
            ST_MC: begin
               ctl.stall_if  = id_valid;
               ctl.bubble_ex = 1'b1;
            end
            ST_FLUSH: begin
               ctl.kill_if   = 1'b1;
               ctl.bubble_ex = 1'b1;
            end
            default: ctl = '0;
         endcase
      end
   end

   assign issue     = ctl.issue;
   assign stall_if  = ctl.stall_if;
   assign bubble_ex = ctl.bubble_ex;
   assign kill_if   = ctl.kill_if;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         flush_cnt <= '0;
         mc_cnt    <= '0;
         mc_rd     <= '0;
         mc_err    <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               // A jump takes priority over entering the multi-cycle wait.
               if (ctl.issue && jmp) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= 3'(FLUSH_CYCLES - 1);
               end else if (ctl.issue && id_multi) begin
                  state  <= ST_MC;
                  mc_cnt <= '0;
                  mc_rd  <= id_we ? id_rd : '0;
               end
            end
            ST_MC: begin
               if (mc_done) begin
                  state <= ST_RUN;
               end else if (wd_fire) begin
                  mc_err <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  mc_cnt <= mc_cnt + 1'b1;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == '0)
                  state <= ST_RUN;
               else
                  flush_cnt <= flush_cnt - 1'b1;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   reg_scoreboard #(.NREGS(NREGS), .IW(IW)) u_sb (
      .clk       (clk),
      .reset     (reset),
      .set_en    (ctl.issue & id_we),
      .set_idx   (id_rd),
      .clr_en    (wb_valid),
      .clr_idx   (wb_rd),
      .abort_en  (wd_fire),
      .abort_idx (mc_rd),
      .rd_idx_a  (id_rs1),
      .rd_idx_b  (id_rs2),
      .busy_a    (busy1),
      .busy_b    (busy2),
      .busy      (sb_busy)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MC_MAX_CYCLES=34, NREGS=32).
// Each cycle the expected output vector {mc_err, kill_if, bubble_ex,
// stall_if, issue, sb_busy} is computed by a behavioural model from the
// driven inputs, pushed to exp_q, and popped and compared at the negedge.
module tb_pipe_hazard_ctrl;

   localparam int FC    = 2;
   localparam int MCMAX = 34;
   localparam int VW    = 37;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_we, id_multi, jmp;
   logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic       wb_valid, mc_done;
   logic       issue, stall_if, bubble_ex, kill_if, mc_err;
   logic [31:0] sb_busy;

   logic [VW-1:0] exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int        m_st;     // 0 RUN, 1 MC_WAIT, 2 FLUSH
   bit [31:0] m_sb;
   int        m_fc, m_mc, m_mrd;
   bit        m_err;
   bit        e_iss, e_st, e_bub, e_kill;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MC_MAX_CYCLES(MCMAX), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_we(id_we), .id_multi(id_multi), .jmp(jmp),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .mc_done(mc_done),
      .issue(issue), .stall_if(stall_if), .bubble_ex(bubble_ex),
      .kill_if(kill_if), .mc_err(mc_err), .sb_busy(sb_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit m_busy(input int r);
      bit b;
      b = (r != 0) && m_sb[r];
`ifdef PIPE_HAZARD_CTRL_WB_BYPASS_EN
      if (wb_valid && (int'(wb_rd) == r))
         b = 1'b0;
`endif
      return b;
   endfunction

   task automatic model_reset();
      m_st = 0; m_sb = '0; m_fc = 0; m_mc = 0; m_mrd = 0; m_err = 1'b0;
   endtask

   task automatic model_comb();
      bit haz;
      haz = id_valid && ((id_use_rs1 && m_busy(int'(id_rs1))) ||
                         (id_use_rs2 && m_busy(int'(id_rs2))));
      e_iss = 1'b0; e_st = 1'b0; e_bub = 1'b1; e_kill = 1'b0;
      if (m_st == 0) begin
         e_iss = id_valid && !haz;
         e_st  = id_valid && haz;
         e_bub = !e_iss;
      end else if (m_st == 1) begin
         e_st = id_valid;
      end else begin
         e_kill = 1'b1;
      end
   endtask

   task automatic model_update();
      bit [31:0] nsb;
      bit wd;
      nsb = m_sb;
      wd  = (m_st == 1) && !mc_done && (m_mc == MCMAX - 1);
      if (wb_valid) nsb[wb_rd] = 1'b0;
      if (wd) nsb[m_mrd] = 1'b0;
      if (e_iss && id_we && id_rd != 5'd0) nsb[id_rd] = 1'b1;
      m_sb = nsb;
      case (m_st)
         0: if (e_iss && jmp) begin
               m_st = 2; m_fc = FC - 1;
            end else if (e_iss && id_multi) begin
               m_st = 1; m_mc = 0; m_mrd = id_we ? int'(id_rd) : 0;
            end
         1: if (mc_done) m_st = 0;
            else if (wd) begin m_err = 1'b1; m_st = 0; end
            else m_mc++;
         default: if (m_fc == 0) m_st = 0; else m_fc--;
      endcase
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_rd = 0; id_we = 0; id_multi = 0; jmp = 0; wb_valid = 0; wb_rd = 0;
      mc_done = 0;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                        input logic we);
      id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = 0; id_use_rs2 = 0;
      id_rd = rd; id_we = we;
   endtask

   // One clock: called at posedge+1 with inputs already driven.
   task automatic run_cycle(input string tag);
      logic [VW-1:0] exp;
      model_comb();
      exp_q.push_back({m_err, e_kill, e_bub, e_st, e_iss, m_sb});
      @(negedge clk);
      exp = exp_q.pop_front();
      check(tag, {mc_err, kill_if, bubble_ex, stall_if, issue, sb_busy}, exp);
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Reset asserted mid-cycle: outputs must drop at once, even with id_valid high.
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1 check(tag, {mc_err, kill_if, bubble_ex, stall_if, issue, sb_busy}, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   initial begin
      idle();
      id_valid = 1;
      reset = 1'b1;
      model_reset();
      #1 check("reset_out", {mc_err, kill_if, bubble_ex, stall_if, issue, sb_busy}, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle();
      run_cycle("idle");

      // RAW stall on x5 until writeback
      instr(5'd0, 0, 5'd5, 1); run_cycle("raw_prod");
      instr(5'd5, 1, 5'd6, 1);
      for (int i = 0; i < 3; i++) run_cycle("raw_stall");
      wb_valid = 1; wb_rd = 5'd5; run_cycle("raw_wb");
      wb_valid = 0; run_cycle("raw_after");
      idle(); wb_valid = 1; wb_rd = 5'd6; run_cycle("raw_clr6");
      check("sb_clear", {5'd0, sb_busy}, '0);

      // set/clear collision on x3, rd=0 never busy
      idle(); instr(5'd0, 0, 5'd3, 1); run_cycle("col_set");
      instr(5'd0, 0, 5'd3, 1); wb_valid = 1; wb_rd = 5'd3; run_cycle("col_both");
      check("col_bit3", {36'd0, sb_busy[3]}, {36'd0, 1'b1});
      idle(); wb_valid = 1; wb_rd = 5'd3; run_cycle("col_clr");
      idle(); instr(5'd0, 0, 5'd0, 1); run_cycle("x0_write");
      idle(); instr(5'd0, 1, 5'd1, 0); run_cycle("x0_read");

      // jump flush: 2 kill cycles, jmp ignored while stalled
      idle(); instr(5'd0, 0, 5'd8, 1); run_cycle("jmp_prod");
      instr(5'd8, 1, 5'd0, 0); jmp = 1; run_cycle("jmp_stalled");
      wb_valid = 1; wb_rd = 5'd8; run_cycle("jmp_wb");
      wb_valid = 0; instr(5'd0, 0, 5'd0, 0); jmp = 1; run_cycle("jmp_take");
      jmp = 0;
      for (int i = 0; i < FC; i++) run_cycle("flush");
      run_cycle("flush_done");
      id_multi = 1; jmp = 1; run_cycle("jmp_vs_multi");
      id_multi = 0; jmp = 0;
      for (int i = 0; i < FC + 1; i++) run_cycle("flush2");

      // multi-cycle op, mc_done after 10 cycles; stray mc_done in RUN
      idle(); mc_done = 1; instr(5'd0, 0, 5'd0, 0); run_cycle("stray_done");
      mc_done = 0; instr(5'd0, 0, 5'd7, 1); id_multi = 1; run_cycle("mc_issue");
      id_multi = 0; instr(5'd1, 0, 5'd0, 0);
      for (int i = 0; i < 9; i++) run_cycle("mc_wait");
      mc_done = 1; run_cycle("mc_done");
      mc_done = 0; run_cycle("mc_resume");
      check("mc_bit7", {36'd0, sb_busy[7]}, {36'd0, 1'b1});
      idle(); wb_valid = 1; wb_rd = 5'd7; run_cycle("mc_wb");

      // watchdog
      idle(); instr(5'd0, 0, 5'd9, 1); id_multi = 1; run_cycle("wd_issue");
      idle();
      for (int i = 0; i < MCMAX; i++) run_cycle("wd_wait");
      check("wd_err", {36'd0, mc_err}, {36'd0, 1'b1});
      check("wd_bit9", {36'd0, sb_busy[9]}, {36'd0, 1'b0});
      instr(5'd9, 1, 5'd0, 0); run_cycle("wd_run");

      // reset during FLUSH
      idle(); instr(5'd0, 0, 5'd4, 1); jmp = 1; run_cycle("rf_jmp");
      jmp = 0; run_cycle("rf_flush");
      async_reset("rst_flush");
      idle(); instr(5'd4, 1, 5'd0, 0); run_cycle("rf_after");

      // reset during MC_WAIT
      idle(); instr(5'd0, 0, 5'd11, 1); id_multi = 1; run_cycle("rm_issue");
      id_multi = 0; id_valid = 1; run_cycle("rm_wait");
      async_reset("rst_mc");
      idle(); instr(5'd11, 1, 5'd0, 0); run_cycle("rm_after");

      // random traffic
      for (int i = 0; i < 250; i++) begin
         id_valid   = 1'($urandom_range(0, 3) != 0);
         id_rs1     = 5'($urandom_range(0, 7));
         id_rs2     = 5'($urandom_range(0, 7));
         id_use_rs1 = 1'($urandom_range(0, 1));
         id_use_rs2 = 1'($urandom_range(0, 1));
         id_rd      = 5'($urandom_range(0, 7));
         id_we      = 1'($urandom_range(0, 1));
         id_multi   = 1'($urandom_range(0, 19) == 0);
         jmp        = 1'($urandom_range(0, 6) == 0);
         wb_valid   = 1'($urandom_range(0, 4) < 2);
         wb_rd      = 5'($urandom_range(0, 7));
         mc_done    = 1'($urandom_range(0, 5) == 0);
         run_cycle("rand");
      end

      check("exp_q_empty", VW'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
